// File: rtl/alu_out_sel.sv
// ALU output selector: picks one of NSRC result sources, registers it with flags behind a valid/ready handshake.
// Optional sticky-overflow register is built only when ALU_OUT_SEL_STICKY_EN is defined.
module alu_out_sel #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 3,
  parameter int unsigned SELW  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SELW-1:0]         osel,
  input  logic [NSRC*WIDTH-1:0]   src_y,
  input  logic [NSRC-1:0]         src_c,
  input  logic [NSRC-1:0]         src_v,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    c,
  output logic                    v,
  output logic                    z,
  output logic                    n,
  output logic                    sel_err,
  output logic                    sv,
  input  logic                    clr_sticky,
  output logic [15:0]             op_count
);

  localparam int unsigned CNTW    = 16;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
    logic             err;
  } result_t;

  generate
    if (NSRC < 2 || NSRC > (1 << SELW)) begin : g_bad_nsrc
      $error("alu_out_sel: NSRC must be in 2..2**SELW");
    end
  endgenerate

  logic    accept;
  result_t nxt;
  result_t held;

  // Output stage can take a new result when empty or being drained this cycle.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Source mux; out-of-range selects fall back to the adder and flag the error.
  always_comb begin
    nxt     = '0;
    nxt.y   = src_y[WIDTH-1:0];
    nxt.c   = src_c[0];
    nxt.v   = src_v[0];
    nxt.err = 1'b1;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (osel == SELW'(i)) begin
        nxt.y   = src_y[i*WIDTH +: WIDTH];
        nxt.c   = src_c[i];
        nxt.v   = src_v[i];
        nxt.err = 1'b0;
      end
    end
    nxt.z = (nxt.y == '0);
    nxt.n = nxt.y[WIDTH-1];
  end

  // Result register, valid flag and saturating operation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        held      <= nxt;
        if (op_count != CNT_MAX) begin
          op_count <= op_count + CNTW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign y       = held.y;
  assign c       = held.c;
  assign v       = held.v;
  assign z       = held.z;
  assign n       = held.n;
  assign sel_err = held.err;

`ifdef ALU_OUT_SEL_STICKY_EN
  logic sv_q;

  // Sticky overflow: a new overflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q <= 1'b0;
    end else if (accept && nxt.v) begin
      sv_q <= 1'b1;
    end else if (clr_sticky) begin
      sv_q <= 1'b0;
    end
  end

  assign sv = sv_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = clr_sticky;
  assign sv                = 1'b0;
`endif

endmodule

// File: tb/tb_alu_out_sel.sv
// Self-checking bench for alu_out_sel: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_out_sel;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  osel;
  logic [23:0] src_y;
  logic [2:0]  src_c;
  logic [2:0]  src_v;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic        c, v, z, n;
  logic        sel_err;
  logic        sv;
  logic        clr_sticky;
  logic [15:0] op_count;

  int tests;
  int fails;

`ifdef ALU_OUT_SEL_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // Reference model state
  bit       m_valid;
  bit [7:0] m_y;
  bit       m_c, m_v, m_z, m_n, m_err;
  int       m_cnt;
  bit       m_sv;

  alu_out_sel #(.WIDTH(8), .NSRC(3), .SELW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .osel       (osel),
    .src_y      (src_y),
    .src_c      (src_c),
    .src_v      (src_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .c          (c),
    .v          (v),
    .z          (z),
    .n          (n),
    .sel_err    (sel_err),
    .sv         (sv),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_ready();
    return !rst && (!m_valid || out_ready);
  endfunction

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic cycle();
    bit acc;
    int idx;
    acc = in_valid && model_ready();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_y = 0; m_c = 0; m_v = 0; m_z = 0; m_n = 0; m_err = 0;
      m_cnt = 0; m_sv = 0;
    end else begin
      if (acc) begin
        idx     = (osel < 3) ? int'(osel) : 0;
        m_y     = 8'((src_y >> (idx * 8)) % 256);
        m_c     = src_c[idx];
        m_v     = src_v[idx];
        m_z     = (m_y == 0);
        m_n     = (m_y >= 128);
        m_err   = (osel >= 3);
        m_valid = 1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (STICKY) begin
        if (acc && m_v) m_sv = 1;
        else if (clr_sticky) m_sv = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 1; osel = 0; src_y = 0; src_c = 0; src_v = 0; clr_sticky = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    cycle();
    tests++;
    if ({out_valid, y, c, v, z, n, sel_err, sv, op_count} !== 30'd0) begin
      fails++;
      $display("FAIL reset_state got valid=%b y=%h cvzn=%b%b%b%b err=%b sv=%b cnt=%0d exp all 0",
               out_valid, y, c, v, z, n, sel_err, sv, op_count);
    end
    rst = 0;
  endtask

  task automatic test_select();
    do_reset();
    // Illegal select falls back to source 0
    in_valid = 1; out_ready = 1; osel = 2'd3; src_y = {8'h5A, 8'hA5, 8'h00}; src_c = 3'b110; src_v = 3'b110;
    cycle();
    tests++;
    if ({y, z, sel_err, n, c, out_valid} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL illegal_osel got y=%h z=%b err=%b n=%b c=%b valid=%b exp y=00 z=1 err=1 n=0 c=0 valid=1",
               y, z, sel_err, n, c, out_valid);
    end
    osel = 2'd1; src_y = {8'h00, 8'h81, 8'h10}; src_c = 3'b010; src_v = 3'b000;
    cycle();
    tests++;
    if ({y, c, n, z, out_valid, sel_err} !== {8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL legal_osel1 got y=%h c=%b n=%b z=%b valid=%b err=%b exp y=81 c=1 n=1 z=0 valid=1 err=0",
               y, c, n, z, out_valid, sel_err);
    end
    osel = 2'd2; src_y = {8'h7F, 8'h00, 8'h00}; src_c = 3'b000; src_v = 3'b100;
    cycle();
    tests++;
    if ({y, v, n, z} !== {8'h7F, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL legal_osel2 got y=%h v=%b n=%b z=%b exp y=7f v=1 n=0 z=0", y, v, n, z);
    end
    in_valid = 0;
    cycle();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1; out_ready = 1; osel = 0; src_y = 24'h000011;
    cycle();
    out_ready = 0; src_y = 24'h000022;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      cycle();
      tests++;
      if ({y, out_valid} !== {8'h11, 1'b1}) begin
        fails++;
        $display("FAIL bp_hold[%0d] got y=%h valid=%b exp y=11 valid=1", i, y, out_valid);
      end
    end
    out_ready = 1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    cycle();
    tests++;
    if ({y, out_valid, op_count} !== {8'h22, 1'b1, 16'd2}) begin
      fails++;
      $display("FAIL bp_accept_b got y=%h valid=%b cnt=%0d exp y=22 valid=1 cnt=2", y, out_valid, op_count);
    end
    in_valid = 0;
  endtask

  task automatic test_back_to_back();
    int vcount;
    do_reset();
    vcount = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      osel = 2'(i % 3); src_y = 24'($urandom);
      cycle();
      if (out_valid === 1'b1) vcount++;
    end
    in_valid = 0;
    tests++;
    if (vcount != 5) begin fails++; $display("FAIL stream_valid_cycles got=%0d exp=5", vcount); end
    tests++;
    if (op_count !== 16'd5) begin fails++; $display("FAIL stream_op_count got=%0d exp=5", op_count); end
    cycle();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      src_y = 24'($urandom);
      cycle();
    end
    in_valid = 1; out_ready = 0;
    tests++;
    if ({out_valid, op_count} !== {1'b1, 16'd7}) begin
      fails++;
      $display("FAIL pre_reset got valid=%b cnt=%0d exp valid=1 cnt=7", out_valid, op_count);
    end
    rst = 1;
    cycle();
    tests++;
    if ({out_valid, op_count, in_ready} !== {1'b0, 16'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_discard got valid=%b cnt=%0d in_ready=%b exp 0/0/0", out_valid, op_count, in_ready);
    end
    rst = 0;
    in_valid = 0; out_ready = 1;
  endtask

  task automatic test_sticky();
    bit exp_sv;
    do_reset();
    in_valid = 1; out_ready = 1; osel = 2'd1; src_v = 3'b010;
    cycle();
    exp_sv = STICKY;
    tests++;
    if (sv !== exp_sv) begin fails++; $display("FAIL sticky_set got=%b exp=%b", sv, exp_sv); end
    clr_sticky = 1;
    cycle();
    tests++;
    if (sv !== exp_sv) begin fails++; $display("FAIL sticky_set_wins got=%b exp=%b", sv, exp_sv); end
    in_valid = 0;
    cycle();
    tests++;
    if (sv !== 1'b0) begin fails++; $display("FAIL sticky_clear got=%b exp=0", sv); end
    clr_sticky = 0; src_v = 0;
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      osel       = 2'($urandom);
      src_y      = 24'($urandom);
      src_c      = 3'($urandom);
      src_v      = 3'($urandom);
      clr_sticky = ($urandom_range(0, 3) == 0);
      #1;
      exp_rdy = model_ready();
      tests++;
      if (in_ready !== exp_rdy) begin
        fails++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy);
      end
      cycle();
      tests++;
      if (out_valid !== m_valid) begin
        fails++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", i, out_valid, m_valid);
      end
      tests++;
      if ({y, c, v, z, n, sel_err} !== {m_y, m_c, m_v, m_z, m_n, m_err}) begin
        fails++;
        $display("FAIL rnd_result[%0d] got y=%h cvzn=%b%b%b%b err=%b exp y=%h cvzn=%b%b%b%b err=%b",
                 i, y, c, v, z, n, sel_err, m_y, m_c, m_v, m_z, m_n, m_err);
      end
      tests++;
      if (op_count !== 16'(m_cnt)) begin
        fails++; $display("FAIL rnd_op_count[%0d] got=%0d exp=%0d", i, op_count, m_cnt);
      end
      tests++;
      if (sv !== m_sv) begin
        fails++; $display("FAIL rnd_sv[%0d] got=%b exp=%b", i, sv, m_sv);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_valid = 0; m_y = 0; m_c = 0; m_v = 0; m_z = 0; m_n = 0; m_err = 0; m_cnt = 0; m_sv = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_select();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_sticky();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_out_sel.md
ALU_OUT_SEL -- requirements
Module: alu_out_sel

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of every source and of y.
REQ-002 Parameter NSRC, default 3, SHALL set the number of sources; legal range 2..2**SELW.
REQ-003 Parameter SELW, default 2, SHALL set the osel width.
REQ-004 Ports, in order:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  source operands and osel are valid.
- in_ready  output  1  block can accept.
- osel  input  SELW  source select; index 0 is the adder.
- src_y  input  NSRC*WIDTH  packed results; source i at bits [i*WIDTH +: WIDTH].
- src_c  input  NSRC  carry per source; bit i is source i.
- src_v  input  NSRC  overflow per source; bit i is source i.
- out_valid  output  1  registered result is valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  registered result.
- c, v  output  1 each  registered carry and overflow.
- z, n  output  1 each  registered zero flag (y==0) and sign flag (y[WIDTH-1]).
- sel_err  output  1  registered; the held result came from an illegal osel.
- sv  output  1  sticky overflow.
- clr_sticky  input  1  clears sv.
- op_count  output  16  accepted-operation count.

Function
REQ-005 Accept SHALL occur on a cycle with in_valid && in_ready; in_ready SHALL equal !rst && (!out_valid || out_ready).
REQ-006 On accept, the selected source's y/c/v, the computed z/n and sel_err SHALL be registered; out_valid SHALL be 1 the next cycle (latency 1).
REQ-007 Throughput SHALL be one op per cycle while out_ready=1; accept and drain in the same cycle SHALL replace the held result with no bubble.
REQ-008 While out_valid && !out_ready, y, c, v, z, n and sel_err SHALL hold stable.
REQ-009 out_valid SHALL fall the cycle after a drain (out_valid && out_ready) that has no accept in the same cycle.
REQ-010 osel >= NSRC SHALL select source 0 and set the registered sel_err=1 for that result; legal osel SHALL register sel_err=0.
REQ-011 z and n SHALL be derived from the selected y, never from inputs in the output cycle.
REQ-012 op_count SHALL increment by 1 per accept and saturate at 16'hFFFF.
REQ-013 With in_valid=0, registers other than out_valid (per REQ-009) SHALL hold.

Reset
REQ-014 While rst=1 at a clk edge: out_valid, y, c, v, z, n, sel_err, sv and op_count SHALL become 0.
REQ-015 While rst=1, in_ready SHALL be 0 and no accept SHALL occur.
REQ-016 Reset while out_valid=1 SHALL discard the held result; out_valid=0 the cycle after.

Configuration
REQ-017 Macro ALU_OUT_SEL_STICKY_EN defined: on accept with the selected v=1, sv SHALL be set to 1.
REQ-018 Macro ALU_OUT_SEL_STICKY_EN defined: clr_sticky=1 SHALL clear sv to 0; when set and clear occur in the same cycle, set SHALL win.
REQ-019 Macro ALU_OUT_SEL_STICKY_EN undefined: sv SHALL be constant 0, clr_sticky SHALL be ignored, and no sticky register SHALL be built.

Verification
REQ-020 WIDTH=8, NSRC=3; osel=1, src_y={8'h00,8'h81,8'h10}, src_c=3'b010, in_valid=1, out_ready=1 -> next cycle y=8'h81, c=1, n=1, z=0, out_valid=1.
REQ-021 osel=3 (illegal) with src0 y=8'h00 -> y=8'h00, z=1, sel_err=1.
REQ-022 Back-pressure: accept A=8'h11, hold out_ready=0 for 3 cycles while offering B=8'h22 -> y stays 8'h11, in_ready=0; raise out_ready -> B is accepted that cycle and y=8'h22 the next.
REQ-023 Continuous stream of 5 ops with out_ready=1 -> 5 consecutive out_valid cycles and op_count=5.
REQ-024 rst=1 with out_valid=1 and op_count=7 -> next cycle out_valid=0, op_count=0, in_ready=0 while rst=1.
REQ-025 ALU_OUT_SEL_STICKY_EN defined: accept with v=1 -> sv=1; set and clr_sticky in the same cycle -> sv=1; clr_sticky alone -> sv=0. Macro undefined: sv=0 throughout the same stimulus.
